// File: rtl/serializer_pkg.sv
// Shared types and default sizing for the bit serializer.
//   state_e       : serializer FSM states (PARITY is used only when
//                   SERIALIZER_PARITY_EN is defined)
//   DEFAULT_WIDTH : default word width in bits
//   DEFAULT_DEPTH : default input buffer depth in words
package serializer_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;
    localparam int unsigned DEFAULT_DEPTH = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_e;

endpackage : serializer_pkg

// File: rtl/word_fifo.sv
// Synchronous word FIFO that buffers parallel words ahead of the serializer.
// Ports:
//   clock, reset        : rising-edge clock, synchronous active-high reset
//   push, push_data     : write request and word (ignored while full)
//   pop, pop_data       : read request and head word (ignored while empty)
//   full, empty, count  : registered occupancy status
module word_fifo
    import serializer_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             do_push;
    logic             do_pop;

    // Pointer increment with explicit wrap so non-power-of-two depths also work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // A push is refused while full even if a pop happens on the same edge.
    assign do_push = push && !full_q;
    assign do_pop  = pop && !empty_q;

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (do_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        full_d  = (count_d == CNT_W'(DEPTH));
        empty_d = (count_d == '0);
    end

    // Control state; reset empties the buffer.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // Word storage needs no reset; occupancy guards every read.
    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

    assign pop_data = mem_q[rd_ptr_q];
    assign full     = full_q;
    assign empty    = empty_q;
    assign count    = count_q;

endmodule : word_fifo

// File: rtl/bit_serializer.sv
// Parallel-to-serial converter feeding a downstream pattern detector.
// Words are buffered in word_fifo and shifted out MSB first, one bit per
// cycle; back-to-back words stream with no idle gap.
// Optional feature: define SERIALIZER_PARITY_EN to append one even-parity
// bit (XOR of the word) after bit 0 of every word.
// Ports:
//   clock, reset   : rising-edge clock, synchronous active-high reset
//   data_in        : parallel word, accepted when data_valid && data_ready
//   data_valid     : data_in is valid this cycle
//   data_ready     : buffer not full (from registered state only)
//   sequence_out   : serial bit stream (named sequence_out because
//                    `sequence` is a reserved SystemVerilog keyword)
//   seq_valid      : sequence_out carries a valid bit
//   frame_start    : marks the first (MSB) bit of each word
//   fifo_count     : number of buffered words
module bit_serializer
    import serializer_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         data_in,
    input  logic                     data_valid,
    output logic                     data_ready,
    output logic                     sequence_out,
    output logic                     seq_valid,
    output logic                     frame_start,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int unsigned BIT_CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic                 fifo_full;
    logic                 fifo_empty;
    logic [WIDTH-1:0]     fifo_pop_data;
    logic                 load_c;

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     shift_q, shift_d;
    logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic                 serial_q, serial_d;
    logic                 seq_valid_q, seq_valid_d;
    logic                 frame_start_q, frame_start_d;
`ifdef SERIALIZER_PARITY_EN
    logic                 parity_q, parity_d;
`endif

    word_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (data_valid),
        .push_data (data_in),
        .pop       (load_c),
        .pop_data  (fifo_pop_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign data_ready = !fifo_full;

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: load_c pops the FIFO head into the shift register.
    always_comb begin
        state_d = state_q;
        load_c  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    load_c  = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (bit_cnt_q == '0) begin
`ifdef SERIALIZER_PARITY_EN
                    state_d = PARITY;
`else
                    // Chain straight into the next word to avoid a gap.
                    if (!fifo_empty) begin
                        load_c = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
`endif
                end
            end
`ifdef SERIALIZER_PARITY_EN
            PARITY: begin
                if (!fifo_empty) begin
                    load_c  = 1'b1;
                    state_d = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // Outputs and datapath next values; serial outputs are registered below.
    always_comb begin
        shift_d       = shift_q;
        bit_cnt_d     = bit_cnt_q;
        serial_d      = 1'b0;
        seq_valid_d   = 1'b0;
        frame_start_d = 1'b0;
`ifdef SERIALIZER_PARITY_EN
        parity_d      = parity_q;
`endif
        case (state_q)
            SHIFT: begin
                serial_d      = shift_q[WIDTH-1];
                seq_valid_d   = 1'b1;
                frame_start_d = (bit_cnt_q == BIT_CNT_W'(WIDTH - 1));
                shift_d       = shift_q << 1;
                bit_cnt_d     = bit_cnt_q - BIT_CNT_W'(1);
            end
`ifdef SERIALIZER_PARITY_EN
            PARITY: begin
                serial_d    = parity_q;
                seq_valid_d = 1'b1;
            end
`endif
            default: ;
        endcase
        if (load_c) begin
            shift_d   = fifo_pop_data;
            bit_cnt_d = BIT_CNT_W'(WIDTH - 1);
`ifdef SERIALIZER_PARITY_EN
            parity_d  = ^fifo_pop_data;
`endif
        end
    end

    // Datapath and output registers; reset aborts any word in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            shift_q       <= '0;
            bit_cnt_q     <= '0;
            serial_q      <= 1'b0;
            seq_valid_q   <= 1'b0;
            frame_start_q <= 1'b0;
`ifdef SERIALIZER_PARITY_EN
            parity_q      <= 1'b0;
`endif
        end else begin
            shift_q       <= shift_d;
            bit_cnt_q     <= bit_cnt_d;
            serial_q      <= serial_d;
            seq_valid_q   <= seq_valid_d;
            frame_start_q <= frame_start_d;
`ifdef SERIALIZER_PARITY_EN
            parity_q      <= parity_d;
`endif
        end
    end

    assign sequence_out = serial_q;
    assign seq_valid    = seq_valid_q;
    assign frame_start  = frame_start_q;

endmodule : bit_serializer

// File: tb/tb_bit_serializer.sv
// Self-checking bench for bit_serializer: a word-level model expands every
// accepted word into its expected MSB-first bit stream (plus parity bit when
// SERIALIZER_PARITY_EN is defined) and each scenario compares the recorded
// serial output against it.
module tb_bit_serializer;

    localparam int unsigned W = 8;
    localparam int unsigned D = 4;
`ifdef SERIALIZER_PARITY_EN
    localparam int unsigned FRAME  = W + 1;
    localparam int unsigned FRAME4 = 5;
`else
    localparam int unsigned FRAME  = W;
    localparam int unsigned FRAME4 = 4;
`endif

    logic                  clock = 1'b0;
    logic                  reset = 1'b1;
    logic [W-1:0]          data_in = '0;
    logic                  data_valid = 1'b0;
    logic                  data_ready;
    logic                  sequence_out;
    logic                  seq_valid;
    logic                  frame_start;
    logic [$clog2(D):0]    fifo_count;

    logic [3:0]            data_in4 = '0;
    logic                  data_valid4 = 1'b0;
    logic                  data_ready4;
    logic                  seq4;
    logic                  seq_valid4;
    logic                  frame_start4;
    logic [2:0]            fifo_count4;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int max_cnt = 0;

    typedef struct { int t; logic fs; logic b; } obs_t;
    typedef struct { logic fs; logic b; } exp_t;
    obs_t obs_q[$];
    exp_t exp_q[$];

    bit_serializer #(.WIDTH(W), .DEPTH(D)) u_dut (
        .clock        (clock),
        .reset        (reset),
        .data_in      (data_in),
        .data_valid   (data_valid),
        .data_ready   (data_ready),
        .sequence_out (sequence_out),
        .seq_valid    (seq_valid),
        .frame_start  (frame_start),
        .fifo_count   (fifo_count)
    );

    bit_serializer #(.WIDTH(4), .DEPTH(4)) u_dut4 (
        .clock        (clock),
        .reset        (reset),
        .data_in      (data_in4),
        .data_valid   (data_valid4),
        .data_ready   (data_ready4),
        .sequence_out (seq4),
        .seq_valid    (seq_valid4),
        .frame_start  (frame_start4),
        .fifo_count   (fifo_count4)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Recorder: logs every valid serial bit with the edge number that produced it.
    always @(negedge clock) begin
        if (seq_valid === 1'b1) obs_q.push_back('{t: cyc, fs: frame_start, b: sequence_out});
        if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
    end

    initial begin
        #300000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    // Word-level model: MSB first, frame_start on the first bit, optional parity.
    task automatic model_frame(input logic [W-1:0] w);
        for (int i = int'(W) - 1; i >= 0; i--) exp_q.push_back('{fs: (i == int'(W) - 1), b: w[i]});
`ifdef SERIALIZER_PARITY_EN
        exp_q.push_back('{fs: 1'b0, b: ^w});
`endif
    endtask

    // Holds data_valid until the word is taken; ok=0 if the bound expires.
    task automatic push_word(input logic [W-1:0] w, input int max_wait, output int waited, output bit ok);
        tick();
        data_in = w;
        data_valid = 1'b1;
        ok = 1'b0;
        waited = 0;
        while (!ok && waited < max_wait) begin
            if (data_ready === 1'b1) begin
                @(posedge clock);
                ok = 1'b1;
            end else begin
                tick();
                waited++;
            end
        end
        #1;
        data_valid = 1'b0;
    endtask

    task automatic wait_drain(output bit ok);
        int quiet = 0;
        ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            tick();
            if (seq_valid === 1'b0 && fifo_count === '0) quiet++;
            else quiet = 0;
            if (quiet >= 3) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        data_valid = 1'b0;
        repeat (3) tick();
        checks++; if (seq_valid !== 1'b0) begin failures++; $display("FAIL rst_seq_valid got=%b exp=0", seq_valid); end
        checks++; if (sequence_out !== 1'b0) begin failures++; $display("FAIL rst_sequence got=%b exp=0", sequence_out); end
        checks++; if (frame_start !== 1'b0) begin failures++; $display("FAIL rst_frame_start got=%b exp=0", frame_start); end
        checks++; if (data_ready !== 1'b1) begin failures++; $display("FAIL rst_data_ready got=%b exp=1", data_ready); end
        checks++; if (fifo_count !== '0) begin failures++; $display("FAIL rst_fifo_count got=%0d exp=0", fifo_count); end
        reset = 1'b0;
        repeat (3) tick();
        checks++; if (seq_valid !== 1'b0) begin failures++; $display("FAIL idle_seq_valid got=%b exp=0", seq_valid); end
    endtask

    task automatic test_single(input logic [W-1:0] w);
        int waited; bit ok; int t;
        obs_q.delete(); exp_q.delete();
        model_frame(w);
        push_word(w, 50, waited, ok);
        t = cyc;
        checks++; if (!ok) begin failures++; $display("FAIL single_push word=%h not accepted", w); end
        wait_drain(ok);
        checks++; if (!ok) begin failures++; $display("FAIL single_drain word=%h timeout", w); end
        checks++; if (obs_q.size() != FRAME) begin failures++; $display("FAIL single_len word=%h got=%0d exp=%0d", w, obs_q.size(), FRAME); end
        if (obs_q.size() > 0) begin
            checks++; if (obs_q[0].t != t + 2) begin failures++; $display("FAIL single_latency got=%0d exp=%0d", obs_q[0].t, t + 2); end
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i].b !== exp_q[i].b || obs_q[i].fs !== exp_q[i].fs)
                begin failures++; $display("FAIL single_bit%0d word=%h got b=%b fs=%b exp b=%b fs=%b", i, w, obs_q[i].b, obs_q[i].fs, exp_q[i].b, exp_q[i].fs); end
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] words [3];
        int waited; bit ok;
        words[0] = 8'hFF; words[1] = 8'h00; words[2] = 8'h3C;
        obs_q.delete(); exp_q.delete();
        for (int k = 0; k < 3; k++) begin
            model_frame(words[k]);
            push_word(words[k], 50, waited, ok);
            checks++; if (!ok) begin failures++; $display("FAIL b2b_push%0d not accepted", k); end
        end
        wait_drain(ok);
        checks++; if (!ok) begin failures++; $display("FAIL b2b_drain timeout"); end
        checks++; if (obs_q.size() != 3 * FRAME) begin failures++; $display("FAIL b2b_len got=%0d exp=%0d", obs_q.size(), 3 * FRAME); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i].b !== exp_q[i].b || obs_q[i].fs !== exp_q[i].fs)
                begin failures++; $display("FAIL b2b_bit%0d got b=%b fs=%b exp b=%b fs=%b", i, obs_q[i].b, obs_q[i].fs, exp_q[i].b, exp_q[i].fs); end
            checks++;
            if (obs_q[i].t != obs_q[0].t + i)
                begin failures++; $display("FAIL b2b_gap bit%0d got cyc=%0d exp=%0d", i, obs_q[i].t, obs_q[0].t + i); end
        end
    endtask

    task automatic test_fifo_full();
        logic [W-1:0] w;
        int waited; bit ok;
        obs_q.delete(); exp_q.delete();
        w = W'($urandom);
        model_frame(w);
        push_word(w, 50, waited, ok);
        checks++; if (!ok) begin failures++; $display("FAIL full_push0 not accepted"); end
        repeat (2) tick();
        max_cnt = 0;
        for (int k = 1; k <= 5; k++) begin
            w = W'($urandom);
            model_frame(w);
            push_word(w, 60, waited, ok);
            checks++; if (!ok) begin failures++; $display("FAIL full_push%0d not accepted", k); end
            checks++;
            if (k < 5 && waited != 0) begin failures++; $display("FAIL full_stall%0d got waited=%0d exp=0", k, waited); end
            else if (k == 5 && waited == 0) begin failures++; $display("FAIL full_stall5 got waited=0 exp>0"); end
        end
        wait_drain(ok);
        checks++; if (!ok) begin failures++; $display("FAIL full_drain timeout"); end
        checks++; if (max_cnt != 4) begin failures++; $display("FAIL full_peak got=%0d exp=4", max_cnt); end
        checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL full_len got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i].b !== exp_q[i].b || obs_q[i].fs !== exp_q[i].fs)
                begin failures++; $display("FAIL full_bit%0d got b=%b fs=%b exp b=%b fs=%b", i, obs_q[i].b, obs_q[i].fs, exp_q[i].b, exp_q[i].fs); end
        end
    endtask

    task automatic test_random();
        logic [W-1:0] w;
        int waited; bit ok;
        obs_q.delete(); exp_q.delete();
        for (int k = 0; k < 16; k++) begin
            w = W'($urandom);
            model_frame(w);
            push_word(w, 80, waited, ok);
            checks++; if (!ok) begin failures++; $display("FAIL rand_push%0d not accepted", k); end
            repeat ($urandom_range(0, 12)) tick();
        end
        wait_drain(ok);
        checks++; if (!ok) begin failures++; $display("FAIL rand_drain timeout"); end
        checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL rand_len got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i].b !== exp_q[i].b || obs_q[i].fs !== exp_q[i].fs)
                begin failures++; $display("FAIL rand_bit%0d got b=%b fs=%b exp b=%b fs=%b", i, obs_q[i].b, obs_q[i].fs, exp_q[i].b, exp_q[i].fs); end
        end
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] w;
        int waited; bit ok; bit seen;
        obs_q.delete(); exp_q.delete();
        w = 8'hC3;
        model_frame(w);
        push_word(w, 50, waited, ok);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin tick(); if (obs_q.size() >= 1) seen = 1'b1; end
        checks++; if (!seen) begin failures++; $display("FAIL midrst_first_bit timeout"); end
        push_word(W'($urandom), 50, waited, ok);
        push_word(W'($urandom), 50, waited, ok);
        seen = (obs_q.size() == 4);
        for (int i = 0; i < 20 && !seen; i++) begin tick(); if (obs_q.size() >= 4) seen = 1'b1; end
        checks++; if (!seen || obs_q.size() != 4) begin failures++; $display("FAIL midrst_fourth_bit got size=%0d exp=4", obs_q.size()); end
        checks++; if (fifo_count !== 3'd2) begin failures++; $display("FAIL midrst_buffered got=%0d exp=2", fifo_count); end
        // Reset on the 4th bit, with a competing push on the same edge.
        reset = 1'b1;
        data_in = W'($urandom);
        data_valid = 1'b1;
        tick();
        checks++; if (seq_valid !== 1'b0) begin failures++; $display("FAIL midrst_seq_valid got=%b exp=0", seq_valid); end
        checks++; if (fifo_count !== '0) begin failures++; $display("FAIL midrst_fifo_count got=%0d exp=0", fifo_count); end
        checks++; if (data_ready !== 1'b1) begin failures++; $display("FAIL midrst_data_ready got=%b exp=1", data_ready); end
        reset = 1'b0;
        data_valid = 1'b0;
        repeat (30) tick();
        checks++; if (obs_q.size() != 4) begin failures++; $display("FAIL midrst_stale got=%0d bits exp=4", obs_q.size()); end
        for (int i = 0; i < obs_q.size() && i < 4; i++) begin
            checks++;
            if (obs_q[i].b !== exp_q[i].b) begin failures++; $display("FAIL midrst_bit%0d got=%b exp=%b", i, obs_q[i].b, exp_q[i].b); end
        end
    endtask

    task automatic test_detector();
        logic [3:0] pattern;
        logic [3:0] hist;
        int n; int detect_at; logic fs_first;
        pattern = 4'b1011;
        hist = '0; n = 0; detect_at = 0; fs_first = 1'b0;
        tick();
        checks++; if (data_ready4 !== 1'b1) begin failures++; $display("FAIL det_ready got=%b exp=1", data_ready4); end
        data_in4 = pattern;
        data_valid4 = 1'b1;
        @(posedge clock);
        #1;
        data_valid4 = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (seq_valid4 === 1'b1) begin
                n++;
                hist = {hist[2:0], seq4};
                if (n == 1) fs_first = frame_start4;
                if (detect_at == 0 && n >= 4 && hist == pattern) detect_at = n;
            end
        end
        checks++; if (detect_at != 4) begin failures++; $display("FAIL det_flag_bit got=%0d exp=4", detect_at); end
        checks++; if (fs_first !== 1'b1) begin failures++; $display("FAIL det_frame_start got=%b exp=1", fs_first); end
        checks++; if (n != FRAME4) begin failures++; $display("FAIL det_len got=%0d exp=%0d", n, FRAME4); end
    endtask

    initial begin
        test_reset();
        test_single(8'hA5);
        test_single(8'h07);
        test_back_to_back();
        test_fifo_full();
        test_random();
        test_reset_mid();
        test_detector();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_bit_serializer

// File: doc/bit_serializer.md
BIT_SERIALIZER -- requirements
Module: bit_serializer

Interface
REQ-001 Parameter: WIDTH, default 8, word width in bits.
REQ-002 Parameter: DEPTH, default 4, input buffer depth in words (power of two).
REQ-003 The block SHALL use one clock and a synchronous, active-high reset, with the ports named clock and reset.
REQ-004 Port: clock  input  1  rising-edge clock for all state.
REQ-005 Port: reset  input  1  synchronous active-high reset.
REQ-006 Port: data_in  input  WIDTH  parallel word to serialize.
REQ-007 Port: data_valid  input  1  data_in is valid this cycle.
REQ-008 Port: data_ready  output  1  block can accept a word this cycle.
REQ-009 Port: sequence  output  1  serial bit stream to the downstream pattern detector.
REQ-010 Port: seq_valid  output  1  sequence carries a valid bit this cycle.
REQ-011 Port: frame_start  output  1  pulse marking the first bit of each word.
REQ-012 Port: fifo_count  output  $clog2(DEPTH)+1  buffered word count.

Function
REQ-013 A word SHALL be accepted on a rising edge where data_valid && data_ready.
REQ-014 data_ready SHALL equal !full, registered-state based, with no combinational path from data_valid.
REQ-015 When full, the block SHALL NOT accept a word, even if a pop occurs in the same cycle.
REQ-016 A simultaneous push and pop when neither full nor empty SHALL leave fifo_count unchanged.
REQ-017 FIFO pointers SHALL wrap modulo DEPTH.
REQ-018 The FSM SHALL have states IDLE, SHIFT and PARITY; PARITY exists only per REQ-030.
REQ-019 IDLE: if the FIFO is non-empty, the block SHALL pop the head into a WIDTH-bit shift register, load bit counter = WIDTH-1, and go to SHIFT; otherwise it SHALL stay in IDLE.
REQ-020 SHIFT: the block SHALL drive sequence = shift register MSB with seq_valid=1, shift left by one, and decrement the counter each cycle.
REQ-021 frame_start SHALL be 1 only on the cycle carrying bit WIDTH-1 of a word.
REQ-022 On the last bit (counter = 0) with no parity, if the FIFO is non-empty the block SHALL pop the next word that same cycle and continue in SHIFT with no gap; otherwise it SHALL go to IDLE.
REQ-023 Latency SHALL be: a word accepted at edge t into an empty, idle block produces its first bit at edge t+2 (registered outputs).
REQ-024 Bit order SHALL be MSB first, so word 4'bABCD presents A, B, C, D matching the detector's in[3]..in[0] order.
REQ-025 In IDLE the block SHALL drive seq_valid=0, sequence=0 and frame_start=0.
REQ-026 sequence, seq_valid and frame_start SHALL be registered outputs.

Reset
REQ-027 On reset the block SHALL set: FSM=IDLE, FIFO emptied (pointers=0, fifo_count=0), data_ready=1, sequence=0, seq_valid=0, frame_start=0.
REQ-028 Reset asserted mid-word SHALL abort the word; no further bits of it or of buffered words SHALL appear.
REQ-029 Reset SHALL take priority over a simultaneous push.

Configuration
REQ-030 Macro SERIALIZER_PARITY_EN: when defined, after bit 0 the FSM SHALL enter PARITY for one cycle, driving sequence = even parity (XOR of the word's bits) with seq_valid=1 and frame_start=0, then apply the REQ-022 pop/IDLE decision.
REQ-031 Without SERIALIZER_PARITY_EN, the PARITY state and its logic SHALL be absent, and frames SHALL be exactly WIDTH bits.

Structure
REQ-032 Package serializer_pkg SHALL hold the FSM state enum (IDLE, SHIFT, PARITY) and the default WIDTH/DEPTH constants.
REQ-033 The buffer SHALL be a sub-module word_fifo (synchronous FIFO with push, pop, full, empty and count).
REQ-034 The top level SHALL contain only the FSM, shift register, counter and parity logic.

Verification
REQ-035 Reset, then push 8'hA5 once -> frame_start at edge t+2; sequence 1,0,1,0,0,1,0,1 on consecutive cycles; then seq_valid=0.
REQ-036 Push 8'hFF, 8'h00 and 8'h3C back-to-back -> 24 contiguous valid bits with no gap; frame_start every 8th cycle.
REQ-037 Push 5 words while output is busy -> the 5th push stalls with data_ready=0 until the first pop; fifo_count peaks at 4; all words are emitted in order.
REQ-038 Assert reset on the 4th bit of 8'hC3 with 2 words buffered -> next cycle seq_valid=0, fifo_count=0, data_ready=1, and no stale bits follow.
REQ-039 With SERIALIZER_PARITY_EN, push 8'h07 -> bits 0,0,0,0,0,1,1,1 followed by parity 1; frame length 9.
REQ-040 With 4'b1011 serialized at WIDTH=4 into the downstream detector configured for 4'b1011 -> detector flag asserts on the 4th bit.
